bp_dram_channel_responder: RTL

//  Single-channel DRAM responder: the far end of the DRAM channel protocol that the core-side mem-to-DRAM bridge drives.
//  - Accepts address/command beats and byte-masked write-data beats.
//  - Stores write data in a word-addressed backing array.
//  - Returns read data tagged with its channel address after a fixed latency.

---
 rtl/bp_dram_channel_responder_pkg.sv | 15 +
 rtl/bp_dram_read_pipe.sv | 39 +++
 rtl/bp_dram_channel_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bp_dram_channel_responder_pkg.sv
// Shared types and helpers for the DRAM channel responder.
// Command decode classes and byte-offset width helper.
package bp_dram_channel_responder_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_WRITE,
    CMD_READ
  } cmd_e;

  function automatic int lg_bytes(input int dw);
    return $clog2(dw / 8);
  endfunction

endpackage

// File: rtl/bp_dram_read_pipe.sv
// Fixed-depth valid+payload shift pipe with no stall.
// Downstream space is guaranteed by read credits.
module bp_dram_read_pipe #(
  parameter int width_p = 80,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o
);

  logic [els_p-1:0]   v_q;
  logic [width_p-1:0] d_q [els_p];

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_q <= '0;
    end else begin
      v_q[0] <= v_i;
      for (int i = 1; i < els_p; i++) begin
        v_q[i] <= v_q[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    d_q[0] <= data_i;
    for (int i = 1; i < els_p; i++) begin
      d_q[i] <= d_q[i-1];
    end
  end

  assign v_o    = v_q[els_p-1];
  assign data_o = d_q[els_p-1];

endmodule

// File: rtl/bp_dram_channel_responder.sv
// DRAM channel responder: byte-masked writes into a backing
// array, fixed-latency tagged reads through a credited FIFO.
module bp_dram_channel_responder
  import bp_dram_channel_responder_pkg::*;
#(
  parameter int channel_addr_width_p = 16,
  parameter int data_width_p         = 64,
  parameter int mem_els_p            = 1024,
  parameter int read_latency_p       = 4,
  parameter int resp_fifo_els_p      = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [channel_addr_width_p-1:0] dram_ch_addr_i,
  input  logic                            dram_write_not_read_i,
  input  logic                            dram_v_i,
  output logic                            dram_yumi_o,
  input  logic [data_width_p-1:0]         dram_data_i,
  input  logic [data_width_p/8-1:0]       dram_mask_i,
  input  logic                            dram_data_v_i,
  output logic                            dram_data_yumi_o,
  output logic [data_width_p-1:0]         dram_data_o,
  output logic [channel_addr_width_p-1:0] dram_ch_addr_o,
  output logic                            dram_data_v_o,
  input  logic                            dram_data_ready_i
);

  localparam int CAW  = channel_addr_width_p;
  localparam int DW   = data_width_p;
  localparam int MW   = DW / 8;
  localparam int OFF  = lg_bytes(DW);
  localparam int IW   = $clog2(mem_els_p);
  localparam int F    = resp_fifo_els_p;
  localparam int CW   = $clog2(F + 1);
  localparam int PTRW = (F > 1) ? $clog2(F) : 1;
  localparam int PW   = CAW + DW;

  logic [DW-1:0]   mem_q [mem_els_p];
  logic [CAW-1:0]  addr_sh;
  logic [IW-1:0]   idx;
  logic [CW-1:0]   credits_q, credits_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PTRW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0]   fifo_q [F];
  logic            pipe_v;
  logic [PW-1:0]   pipe_data;
  logic            wr_fire, rd_fire, pop;
  cmd_e            cmd;

  assign addr_sh = dram_ch_addr_i >> OFF;
  assign idx     = addr_sh[IW-1:0];

  always_comb begin
    cmd = CMD_IDLE;
    if (reset_n_i && dram_v_i) begin
      if (dram_write_not_read_i && dram_data_v_i) cmd = CMD_WRITE;
      else if (!dram_write_not_read_i && credits_q != '0) cmd = CMD_READ;
    end
  end

  always_comb begin
    wr_fire = 1'b0;
    rd_fire = 1'b0;
    unique case (1'b1)
      (cmd == CMD_WRITE): wr_fire = 1'b1;
      (cmd == CMD_READ):  rd_fire = 1'b1;
      default: ;
    endcase
  end

  assign dram_yumi_o      = wr_fire | rd_fire;
  assign dram_data_yumi_o = wr_fire;

  // Backing array survives reset by design.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      for (int b = 0; b < MW; b++) begin
        if (dram_mask_i[b]) mem_q[idx][b*8 +: 8] <= dram_data_i[b*8 +: 8];
      end
    end
  end

  bp_dram_read_pipe #(
    .width_p(PW),
    .els_p  (read_latency_p)
  ) u_pipe (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (rd_fire),
    .data_i   ({dram_ch_addr_i, mem_q[idx]}),
    .v_o      (pipe_v),
    .data_o   (pipe_data)
  );

  assign dram_data_v_o = reset_n_i && (cnt_q != '0);
  assign pop           = dram_data_v_o && dram_data_ready_i;

  assign {dram_ch_addr_o, dram_data_o} =
    dram_data_v_o ? fifo_q[rptr_q] : '0;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (pipe_v) wptr_d = (wptr_q == PTRW'(F-1)) ? '0 : wptr_q + 1'b1;
    if (pop)    rptr_d = (rptr_q == PTRW'(F-1)) ? '0 : rptr_q + 1'b1;
    cnt_d     = cnt_q + CW'(pipe_v) - CW'(pop);
    credits_d = credits_q - CW'(rd_fire) + CW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      credits_q <= CW'(F);
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      cnt_q     <= cnt_d;
      credits_q <= credits_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (pipe_v && reset_n_i) fifo_q[wptr_q] <= pipe_data;
  end

  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (credits_q <= CW'(F));
      assert (!(pop && !rd_fire && credits_q == CW'(F)));
      assert (!(rd_fire && credits_q == '0));
    end
  end

endmodule
